pos_packet_tx: RTL and testbench

Serializes one snapshot of local tank position and mouse cursor position into a fixed 10-byte packet for the inter-board link. It accepts the same four position fields the rendering pipeline registers and emits bytes over a valid/ready byte stream into the UART transmitter. The remote board's packet receiver reconstructs the fields for its own position pipeline. Runs in the `clk` domain, with one snapshot requested per video frame.

---
 rtl/pos_pkt_pkg.sv | 38 +++
 rtl/pos_pkt_byte_mux.sv | 37 +++
 rtl/pos_packet_tx.sv | 125 ++++++++++++
 tb/tb_pos_packet_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pos_pkt_pkg
// Description : Shared constants, types and helpers for the position packet
//               transmitter (packet length, byte indices, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package pos_pkt_pkg;

    localparam int PKT_LEN = 10;
    localparam int IDX_W   = 4;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Byte positions inside the packet
    localparam logic [IDX_W-1:0] SYNC_IDX       = IDX_W'(0);
    localparam logic [IDX_W-1:0] CSUM_FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] CSUM_LAST_IDX  = IDX_W'(8);
    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(PKT_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [9:0]  tank_x;
        logic [9:0]  tank_y;
        logic [11:0] mouse_x;
        logic [11:0] mouse_y;
    } snap_t;

    function automatic logic in_csum_range(input logic [IDX_W-1:0] idx);
        return (idx >= CSUM_FIRST_IDX) && (idx <= CSUM_LAST_IDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pos_pkt_byte_mux.sv
`default_nettype none
// ============================================================================
// Module      : pos_pkt_byte_mux
// Description : Selects the outgoing packet byte for a given byte index from
//               the position snapshot, running checksum and sync marker.
// Revision    : 1.0 - initial release
// ============================================================================
module pos_pkt_byte_mux
    import pos_pkt_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  snap_t            snap,
    input  logic [7:0]       csum,
    input  logic [7:0]       sync_byte,
    output logic [7:0]       byte_out
);

    // High byte of each field goes first, zero-padded to 8 bits
    always_comb begin
        byte_out = 8'h00;
        case (idx)
            IDX_W'(0): byte_out = sync_byte;
            IDX_W'(1): byte_out = {6'b0, snap.tank_x[9:8]};
            IDX_W'(2): byte_out = snap.tank_x[7:0];
            IDX_W'(3): byte_out = {6'b0, snap.tank_y[9:8]};
            IDX_W'(4): byte_out = snap.tank_y[7:0];
            IDX_W'(5): byte_out = {4'b0, snap.mouse_x[11:8]};
            IDX_W'(6): byte_out = snap.mouse_x[7:0];
            IDX_W'(7): byte_out = {4'b0, snap.mouse_y[11:8]};
            IDX_W'(8): byte_out = snap.mouse_y[7:0];
            IDX_W'(9): byte_out = csum;
            default:   byte_out = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pos_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : pos_packet_tx
// Description : Snapshots tank and mouse positions and streams them as a
//               10-byte checksummed packet over a valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
module pos_packet_tx
    import pos_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic [9:0]  xpos_tank_in,
    input  logic [9:0]  ypos_tank_in,
    input  logic [11:0] xpos_mouse_in,
    input  logic [11:0] ypos_mouse_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        pkt_done
);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_pending;
    snap_t            r_snap;
    logic [7:0]       r_csum;
    logic             r_tx_valid;
    logic             r_busy;
    logic             r_pkt_done;

    snap_t            w_snap_in;
    logic [7:0]       w_byte;
    logic             w_accept;
    logic             w_last;

    assign w_snap_in = '{
        tank_x:  xpos_tank_in,
        tank_y:  ypos_tank_in,
        mouse_x: xpos_mouse_in,
        mouse_y: ypos_mouse_in
    };

    pos_pkt_byte_mux u_byte_mux (
        .idx       (r_idx),
        .snap      (r_snap),
        .csum      (r_csum),
        .sync_byte (SYNC_BYTE),
        .byte_out  (w_byte)
    );

    assign w_accept = r_tx_valid && tx_ready;
    assign w_last   = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= SYNC_IDX;
            r_pending  <= 1'b0;
            r_snap     <= '0;
            r_csum     <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (send_req) begin
                        r_state    <= SEND;
                        r_snap     <= w_snap_in;
                        r_idx      <= SYNC_IDX;
                        r_csum     <= 8'h00;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (send_req) begin
                        r_pending <= 1'b1;
                    end
                    if (w_accept) begin
                        if (w_last) begin
                            r_pkt_done <= 1'b1;
                            // A request arriving with the final byte counts as pending
                            if (r_pending || send_req) begin
                                r_pending <= 1'b0;
                                r_snap    <= w_snap_in;
                                r_idx     <= SYNC_IDX;
                                r_csum    <= 8'h00;
                            end else begin
                                r_state    <= IDLE;
                                r_idx      <= SYNC_IDX;
                                r_tx_valid <= 1'b0;
                                r_busy     <= 1'b0;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            if (in_csum_range(r_idx)) begin
                                r_csum <= r_csum ^ w_byte;
                            end
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Idle drives zero rather than whatever byte the index happens to select
    assign tx_data  = r_tx_valid ? w_byte : 8'h00;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign pkt_done = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_pos_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pos_packet_tx
// Description : Self-checking bench for pos_packet_tx: table vectors, corner
//               sequences and randomized traffic against a byte-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pos_packet_tx;

    typedef logic [9:0][7:0] pkt_t;

    typedef struct {
        logic [9:0]  tx;
        logic [9:0]  ty;
        logic [11:0] mx;
        logic [11:0] my;
        pkt_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_req;
    logic [9:0]  tank_x;
    logic [9:0]  tank_y;
    logic [11:0] mouse_x;
    logic [11:0] mouse_y;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        pkt_done;

    int n_vec = 0;
    int n_bad = 0;

    // Byte-stream reference model state
    pkt_t cur;
    int   left     = 0;
    bit   want     = 1'b0;
    bit   done_exp = 1'b0;
    int   n_done   = 0;

    always #5 clk = ~clk;

    pos_packet_tx #(.SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .send_req      (send_req),
        .xpos_tank_in  (tank_x),
        .ypos_tank_in  (tank_y),
        .xpos_mouse_in (mouse_x),
        .ypos_mouse_in (mouse_y),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .pkt_done      (pkt_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pkt_t make_pkt(input logic [9:0] tx, input logic [9:0] ty,
                                      input logic [11:0] mx, input logic [11:0] my);
        pkt_t p;
        p[0] = 8'hA5;
        p[1] = 8'(tx >> 8);
        p[2] = tx[7:0];
        p[3] = 8'(ty >> 8);
        p[4] = ty[7:0];
        p[5] = 8'(mx >> 8);
        p[6] = mx[7:0];
        p[7] = 8'(my >> 8);
        p[8] = my[7:0];
        p[9] = 8'h00;
        for (int i = 1; i <= 8; i++) p[9] = p[9] ^ p[i];
        return p;
    endfunction

    function automatic pkt_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                input logic [7:0] b6, input logic [7:0] b7, input logic [7:0] b8,
                                input logic [7:0] b9);
        pkt_t p;
        p[0] = b0; p[1] = b1; p[2] = b2; p[3] = b3; p[4] = b4;
        p[5] = b5; p[6] = b6; p[7] = b7; p[8] = b8; p[9] = b9;
        return p;
    endfunction

    // One clock: check outputs against the model, drive inputs, advance the model, step.
    task automatic tick(input bit req, input bit rdy);
        send_req = req;
        tx_ready = rdy;
        chk("busy", 32'(busy), 32'(left > 0));
        chk("tx_valid", 32'(tx_valid), 32'(left > 0));
        chk("tx_data", 32'(tx_data), (left > 0) ? 32'(cur[10-left]) : 32'h0);
        chk("pkt_done", 32'(pkt_done), 32'(done_exp));
        if (pkt_done) n_done++;
        done_exp = 1'b0;
        if (left == 0) begin
            if (req) begin
                cur  = make_pkt(tank_x, tank_y, mouse_x, mouse_y);
                left = 10;
            end
        end else begin
            if (req) want = 1'b1;
            if (rdy) begin
                left--;
                if (left == 0) begin
                    done_exp = 1'b1;
                    if (want) begin
                        cur  = make_pkt(tank_x, tank_y, mouse_x, mouse_y);
                        left = 10;
                        want = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        send_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        left = 0; want = 1'b0; done_exp = 1'b0;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pkt_done", 32'(pkt_done), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
    endtask

    task automatic set_fields(input logic [9:0] tx, input logic [9:0] ty,
                              input logic [11:0] mx, input logic [11:0] my);
        tank_x = tx; tank_y = ty; mouse_x = mx; mouse_y = my;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((left > 0 || want) && k < budget) begin
            tick(1'b0, 1'b1);
            k++;
        end
        chk("drain_timeout", 32'(left > 0 || want), 32'h0);
        tick(1'b0, 1'b0);
    endtask

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; send_req = 1'b0; tx_ready = 1'b0;
        set_fields(10'h0, 10'h0, 12'h0, 12'h0);

        vecs[0] = '{10'h2AB, 10'h155, 12'hABC, 12'h123,
                    mk(8'hA5, 8'h02, 8'hAB, 8'h01, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h69)};
        vecs[1] = '{10'h3FF, 10'h3FF, 12'hFFF, 12'hFFF,
                    mk(8'hA5, 8'h03, 8'hFF, 8'h03, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h00)};
        vecs[2] = '{10'h000, 10'h000, 12'h000, 12'h000,
                    mk(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00)};
        vecs[3] = '{10'h100, 10'h001, 12'h800, 12'h0FF,
                    mk(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'hFF, 8'hF7)};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // tx_ready in idle must not start anything
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // Table vectors, full-speed
        foreach (vecs[v]) begin
            set_fields(vecs[v].tx, vecs[v].ty, vecs[v].mx, vecs[v].my);
            tick(1'b1, 1'b1);
            for (int i = 0; i < 10; i++) begin
                chk("tbl_byte", 32'(tx_data), 32'(vecs[v].exp[i]));
                tick(1'b0, 1'b1);
            end
            chk("tbl_done", 32'(pkt_done), 32'h1);
            tick(1'b0, 1'b1);
        end

        // Backpressure with ready pattern 1,0,0,1,...
        set_fields(vecs[0].tx, vecs[0].ty, vecs[0].mx, vecs[0].my);
        tick(1'b1, 1'b1);
        for (int k = 0; k < 60 && left > 0; k++) tick(1'b0, (k % 3) == 0);
        chk("bp_finished", 32'(left), 32'h0);
        tick(1'b0, 1'b0);

        // Snapshot isolation
        set_fields(vecs[0].tx, vecs[0].ty, vecs[0].mx, vecs[0].my);
        tick(1'b1, 1'b1);
        set_fields(10'h0, 10'h0, 12'h0, 12'h0);
        drain(20);

        // Coalesced requests: one follow-up carrying restart-time (zero) inputs
        n_done = 0;
        set_fields(vecs[0].tx, vecs[0].ty, vecs[0].mx, vecs[0].my);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        set_fields(10'h0, 10'h0, 12'h0, 12'h0);
        drain(40);
        chk("coalesce_pkts", 32'(n_done), 32'h2);

        // Request coincident with the final acceptance restarts immediately
        set_fields(vecs[1].tx, vecs[1].ty, vecs[1].mx, vecs[1].my);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);
        set_fields(vecs[3].tx, vecs[3].ty, vecs[3].mx, vecs[3].my);
        tick(1'b1, 1'b1);
        chk("restart_valid", 32'(tx_valid), 32'h1);
        chk("restart_sync", 32'(tx_data), 32'hA5);
        drain(20);

        // Reset while byte 4 is presented
        set_fields(vecs[0].tx, vecs[0].ty, vecs[0].mx, vecs[0].my);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        chk("pre_rst_byte4", 32'(tx_data), 32'h55);
        do_reset();
        tick(1'b0, 1'b1);
        set_fields(vecs[3].tx, vecs[3].ty, vecs[3].mx, vecs[3].my);
        tick(1'b1, 1'b0);
        chk("post_rst_sync", 32'(tx_data), 32'hA5);
        drain(20);

        // Randomized traffic with inputs changing every cycle
        for (int c = 0; c < 1500; c++) begin
            set_fields(10'($urandom), 10'($urandom), 12'($urandom), 12'($urandom));
            tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
        end
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
